eq_cascade: RTL

EQ_CASCADE -- requirements
Module: eq_cascade

---
 rtl/eq_pkg.sv | 31 +++
 rtl/eq_mac.sv | 67 ++++++
 rtl/eq_cascade.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared types and Q-format helpers for the biquad EQ cascade.
// Coefficients are Q2.(COEF_W-2); a value of 1.0 is 2^(COEF_W-2).
package eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WB,
    ST_OUT
  } eq_state_e;

  // Also the MAC step index: step n multiplies coefficient n by its operand.
  typedef enum logic [2:0] {
    SEL_B0 = 3'd0,
    SEL_B1 = 3'd1,
    SEL_B2 = 3'd2,
    SEL_A1 = 3'd3,
    SEL_A2 = 3'd4
  } coef_sel_e;

  localparam int NUM_COEFS = 5;

  function automatic int q_frac(input int coef_w);
    return coef_w - 2;
  endfunction

  function automatic int coef_one(input int coef_w);
    return 1 << q_frac(coef_w);
  endfunction

endpackage

// File: rtl/eq_mac.sv
// Shared-multiplier accumulator for one biquad band, plus the rounding and
// saturation that turn the accumulator into the band output y.
module eq_mac
  import eq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_first,
  input  logic              i_sub,
  input  logic [COEF_W-1:0] i_coef,
  input  logic [DATA_W-1:0] i_sample,
  output logic [DATA_W-1:0] o_y,
  output logic              o_clamp
);

  localparam int PW = DATA_W + COEF_W;
  localparam int AW = DATA_W + COEF_W + 3;
  localparam int SH = q_frac(COEF_W);

  localparam logic signed [AW:0] HALF  = {{(AW + 1 - SH){1'b0}}, 1'b1, {(SH - 1){1'b0}}};
  localparam logic signed [AW:0] MAX_V = {{(AW + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [AW:0] MIN_V = {{(AW + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic [PW-1:0]     prod;
  logic [AW-1:0]     prod_ext;
  logic [AW-1:0]     acc_d, acc_q;
  logic signed [AW:0] rnd;
  logic signed [AW:0] shifted;

  // Both operands sign-extended to the full product width, so the modular
  // product is the exact two's-complement result.
  assign prod     = {{DATA_W{i_coef[COEF_W-1]}}, i_coef} * {{COEF_W{i_sample[DATA_W-1]}}, i_sample};
  assign prod_ext = {{3{prod[PW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (i_en) begin
      if (i_first) acc_d = i_sub ? (AW'(0) - prod_ext) : prod_ext;
      else         acc_d = i_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign rnd     = $signed({acc_q[AW-1], acc_q}) + HALF;
  assign shifted = rnd >>> SH;

  always_comb begin
    o_clamp = 1'b0;
    o_y     = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      o_clamp = 1'b1;
      o_y     = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      o_clamp = 1'b1;
      o_y     = MIN_V[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/eq_cascade.sv
// Cascade of NUM_BANDS biquads sharing one multiplier: 5 MAC + 1 WB cycle per band.
// EQ_CASCADE_SAT_FLAG_EN enables the sticky o_sat clamp flag; otherwise o_sat is 0.
module eq_cascade
  import eq_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_BANDS = 6,
  parameter int COEF_W    = 16,
  localparam int BAND_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_cfg_we,
  input  logic [BAND_W-1:0] i_cfg_band,
  input  logic [2:0]        i_cfg_sel,
  input  logic [COEF_W-1:0] i_cfg_coef,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_sat,
  input  logic              i_clr_sat
);

  localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(coef_one(COEF_W));

  eq_state_e         state_d, state_q;
  logic [BAND_W-1:0] band_d, band_q;
  coef_sel_e         step_d, step_q;
  logic [DATA_W-1:0] x_d, x_q;
  logic [COEF_W-1:0] coef_d [NUM_BANDS][NUM_COEFS];
  logic [COEF_W-1:0] coef_q [NUM_BANDS][NUM_COEFS];
  logic [DATA_W-1:0] x1_d [NUM_BANDS], x1_q [NUM_BANDS];
  logic [DATA_W-1:0] x2_d [NUM_BANDS], x2_q [NUM_BANDS];
  logic [DATA_W-1:0] y1_d [NUM_BANDS], y1_q [NUM_BANDS];
  logic [DATA_W-1:0] y2_d [NUM_BANDS], y2_q [NUM_BANDS];
  logic [DATA_W-1:0] o_data_d, o_data_q;
  logic              o_valid_d, o_valid_q;
  logic [DATA_W-1:0] mac_sample;
  logic [DATA_W-1:0] mac_y;
  logic              mac_clamp;
  logic              cfg_ok;

  always_comb begin
    case (step_q)
      SEL_B0:  mac_sample = x_q;
      SEL_B1:  mac_sample = x1_q[band_q];
      SEL_B2:  mac_sample = x2_q[band_q];
      SEL_A1:  mac_sample = y1_q[band_q];
      SEL_A2:  mac_sample = y2_q[band_q];
      default: mac_sample = '0;
    endcase
  end

  eq_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (state_q == ST_MAC),
    .i_first  (step_q == SEL_B0),
    .i_sub    (step_q == SEL_A1 || step_q == SEL_A2),
    .i_coef   (coef_q[band_q][step_q]),
    .i_sample (mac_sample),
    .o_y      (mac_y),
    .o_clamp  (mac_clamp)
  );

  assign cfg_ok = i_cfg_we && (i_cfg_sel <= 3'd4) && (32'(i_cfg_band) < NUM_BANDS);

  always_comb begin
    state_d   = state_q;
    band_d    = band_q;
    step_d    = step_q;
    x_d       = x_q;
    coef_d    = coef_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The write lands on the same edge as the accept, so the sample sees it.
        if (cfg_ok) coef_d[i_cfg_band][i_cfg_sel] = i_cfg_coef;
        if (i_valid) begin
          x_d     = i_data;
          band_d  = '0;
          step_d  = SEL_B0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (step_q == SEL_A2) state_d = ST_WB;
        else                  step_d  = coef_sel_e'(step_q + 3'd1);
      end
      ST_WB: begin
        x2_d[band_q] = x1_q[band_q];
        x1_d[band_q] = x_q;
        y2_d[band_q] = y1_q[band_q];
        y1_d[band_q] = mac_y;
        x_d          = mac_y;
        if (band_q == BAND_W'(NUM_BANDS - 1)) begin
          state_d = ST_OUT;
        end else begin
          band_d  = band_q + 1'b1;
          step_d  = SEL_B0;
          state_d = ST_MAC;
        end
      end
      ST_OUT: begin
        o_data_d  = x_q;
        o_valid_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      band_q    <= '0;
      step_q    <= SEL_B0;
      x_q       <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        for (int c = 0; c < NUM_COEFS; c++) coef_q[b][c] <= (c == 0) ? COEF_ONE : '0;
        x1_q[b] <= '0;
        x2_q[b] <= '0;
        y1_q[b] <= '0;
        y2_q[b] <= '0;
      end
    end else begin
      state_q   <= state_d;
      band_q    <= band_d;
      step_q    <= step_d;
      x_q       <= x_d;
      coef_q    <= coef_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

`ifdef EQ_CASCADE_SAT_FLAG_EN
  logic sat_d, sat_q;

  // Clear wins over a clamp landing in the same cycle.
  always_comb begin
    sat_d = sat_q;
    if (state_q == ST_WB && mac_clamp) sat_d = 1'b1;
    if (i_clr_sat)                     sat_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign o_sat = sat_q;
`else
  logic unused_sat;
  assign unused_sat = i_clr_sat ^ mac_clamp;
  assign o_sat      = 1'b0;
`endif

endmodule
